// File: rtl/w6host.sv
// w6host: host side of a half-duplex serial link moving 72-bit {addr, data} frames.
// Device-to-host frames take priority; all outputs are registered.
module w6host #(
  parameter int HALF       = 2,
  parameter int FRAME_BITS = 72
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  tx_addr,
  input  logic [63:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_addr,
  output logic [63:0] rx_data,
  output logic        rx_valid,
  output logic        busy,
  output logic        link_clk,
  output logic        link_dir,
  input  logic        link_cts,
  input  logic        link_rts,
  output logic        link_tx,
  input  logic        link_rx
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_TX_WAIT  = 3'd1,
    S_TX_SHIFT = 3'd2,
    S_TX_END   = 3'd3,
    S_RX_SHIFT = 3'd4,
    S_RX_END   = 3'd5
  } state_t;

  localparam logic [7:0] HALF_M1  = 8'(HALF - 1);
  localparam logic [6:0] LAST_BIT = 7'(FRAME_BITS - 1);

  state_t                  state_q, state_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [6:0]              bit_cnt_q, bit_cnt_d;
  logic                    cts_s1_q, cts_s1_d, cts_s2_q, cts_s2_d;
  logic                    rts_s1_q, rts_s1_d, rts_s2_q, rts_s2_d;
  logic                    link_clk_q, link_clk_d;
  logic                    link_dir_q, link_dir_d;
  logic                    link_tx_q, link_tx_d;
  logic                    tx_ready_q, tx_ready_d;
  logic                    busy_q, busy_d;
  logic                    rx_valid_q, rx_valid_d;
  logic [7:0]              rx_addr_q, rx_addr_d;
  logic [63:0]             rx_data_q, rx_data_d;

  // Next-state logic: synchronizers, frame sequencing and link clock generation
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    cts_s1_d   = link_cts;
    cts_s2_d   = cts_s1_q;
    rts_s1_d   = link_rts;
    rts_s2_d   = rts_s1_q;
    link_clk_d = link_clk_q;
    link_dir_d = link_dir_q;
    link_tx_d  = link_tx_q;
    rx_valid_d = 1'b0;
    rx_addr_d  = rx_addr_q;
    rx_data_d  = rx_data_q;

    case (state_q)
      S_IDLE: begin
        if (rts_s2_q) begin
          state_d    = S_RX_SHIFT;
          link_dir_d = 1'b0;
          cnt_d      = 8'd0;
          bit_cnt_d  = 7'd0;
          shift_d    = '0;
        end else if (tx_valid && tx_ready_q) begin
          state_d    = S_TX_WAIT;
          shift_d    = FRAME_BITS'({tx_addr, tx_data});
          link_dir_d = 1'b1;
          link_tx_d  = tx_addr[7];
        end else begin
          state_d = S_IDLE;
        end
      end

      S_TX_WAIT: begin
        if (cts_s2_q) begin
          state_d   = S_TX_SHIFT;
          cnt_d     = 8'd0;
          bit_cnt_d = 7'd0;
        end else begin
          state_d = S_TX_WAIT;
        end
      end

      // A slot is HALF cycles low then HALF cycles high; the slot ends on the fall
      S_TX_SHIFT, S_RX_SHIFT: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = 8'd0;
          if (!link_clk_q) begin
            link_clk_d = 1'b1;
            if (state_q == S_RX_SHIFT) begin
              shift_d = {shift_q[FRAME_BITS-2:0], link_rx};
            end else begin
              shift_d = shift_q;
            end
          end else begin
            link_clk_d = 1'b0;
            bit_cnt_d  = bit_cnt_q + 7'd1;
            if (state_q == S_TX_SHIFT) begin
              shift_d   = {shift_q[FRAME_BITS-2:0], 1'b0};
              link_tx_d = shift_q[FRAME_BITS-2];
            end else begin
              shift_d = shift_q;
            end
            if (bit_cnt_q == LAST_BIT) begin
              state_d = (state_q == S_TX_SHIFT) ? S_TX_END : S_RX_END;
            end else begin
              state_d = state_q;
            end
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_TX_END: begin
        if (cnt_q == HALF_M1) begin
          state_d    = S_IDLE;
          cnt_d      = 8'd0;
          link_dir_d = 1'b0;
          link_tx_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_RX_END: begin
        rx_addr_d  = shift_q[FRAME_BITS-1 -: 8];
        rx_data_d  = shift_q[63:0];
        rx_valid_d = 1'b1;
        bit_cnt_d  = 7'd0;
        state_d    = S_IDLE;
      end

      default: begin
        state_d    = S_IDLE;
        cnt_d      = 8'd0;
        bit_cnt_d  = 7'd0;
        link_clk_d = 1'b0;
        link_dir_d = 1'b0;
        link_tx_d  = 1'b0;
      end
    endcase

    // Status outputs are registered copies derived from the next state
    busy_d     = (state_d != S_IDLE);
    tx_ready_d = (state_d == S_IDLE) && !rts_s2_d;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      cnt_q      <= 8'd0;
      bit_cnt_q  <= 7'd0;
      cts_s1_q   <= 1'b0;
      cts_s2_q   <= 1'b0;
      rts_s1_q   <= 1'b0;
      rts_s2_q   <= 1'b0;
      link_clk_q <= 1'b0;
      link_dir_q <= 1'b0;
      link_tx_q  <= 1'b0;
      tx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_addr_q  <= 8'd0;
      rx_data_q  <= 64'd0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      cts_s1_q   <= cts_s1_d;
      cts_s2_q   <= cts_s2_d;
      rts_s1_q   <= rts_s1_d;
      rts_s2_q   <= rts_s2_d;
      link_clk_q <= link_clk_d;
      link_dir_q <= link_dir_d;
      link_tx_q  <= link_tx_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      rx_valid_q <= rx_valid_d;
      rx_addr_q  <= rx_addr_d;
      rx_data_q  <= rx_data_d;
    end
  end

  assign tx_ready = tx_ready_q;
  assign busy     = busy_q;
  assign rx_valid = rx_valid_q;
  assign rx_addr  = rx_addr_q;
  assign rx_data  = rx_data_q;
  assign link_clk = link_clk_q;
  assign link_dir = link_dir_q;
  assign link_tx  = link_tx_q;

endmodule

// File: tb/tb_w6host.sv
// Bench for w6host: a behavioural link device (bit capture on link_clk rise, bit
// presentation after link_clk fall) checks table-driven and random frames.
module tb_w6host;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Instance with HALF=2
  logic [7:0]  tx_addr;
  logic [63:0] tx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  rx_addr;
  logic [63:0] rx_data;
  logic        rx_valid, busy, link_clk, link_dir, link_cts, link_rts, link_tx, link_rx;

  // Instance with HALF=1
  logic [7:0]  tx_addr1;
  logic [63:0] tx_data1;
  logic        tx_valid1, tx_ready1;
  logic [7:0]  rx_addr1;
  logic [63:0] rx_data1;
  logic        rx_valid1, busy1, link_clk1, link_dir1, link_cts1, link_rts1, link_tx1, link_rx1;

  w6host #(.HALF(2), .FRAME_BITS(72)) u0 (
    .clk(clk), .rst(rst), .tx_addr(tx_addr), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_addr(rx_addr), .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .link_clk(link_clk), .link_dir(link_dir), .link_cts(link_cts),
    .link_rts(link_rts), .link_tx(link_tx), .link_rx(link_rx)
  );

  w6host #(.HALF(1), .FRAME_BITS(72)) u1 (
    .clk(clk), .rst(rst), .tx_addr(tx_addr1), .tx_data(tx_data1), .tx_valid(tx_valid1),
    .tx_ready(tx_ready1), .rx_addr(rx_addr1), .rx_data(rx_data1), .rx_valid(rx_valid1),
    .busy(busy1), .link_clk(link_clk1), .link_dir(link_dir1), .link_cts(link_cts1),
    .link_rts(link_rts1), .link_tx(link_tx1), .link_rx(link_rx1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Device model for u0: what it sees on the wire, independent of host internals
  int          fall_cnt = 0;
  int          rise_cnt = 0;
  int          dir_err  = 0;
  logic [71:0] cap      = 72'd0;
  logic [71:0] dev_frame = 72'd0;
  int          dev_base = 0;
  logic        exp_dir  = 1'b0;
  int          rx_idx;

  always @(negedge link_clk) fall_cnt <= fall_cnt + 1;

  always @(posedge link_clk) begin
    rise_cnt <= rise_cnt + 1;
    cap      <= {cap[70:0], link_tx};
    if (link_dir !== exp_dir) dir_err <= dir_err + 1;
  end

  // Bit i of the outgoing device frame is presented after the i-th link_clk fall
  assign rx_idx  = fall_cnt - dev_base;
  assign link_rx = (rx_idx >= 0 && rx_idx < 72) ? dev_frame[71 - rx_idx] : 1'b0;

  // Wire monitor for u1: capture bits and measure link_clk half-periods in clk cycles
  int          cyc1 = 0;
  int          rise1 = 0;
  int          gap_err1 = 0;
  int          last_rise1 = -1;
  logic        prev1 = 1'b0;
  logic [71:0] cap1 = 72'd0;

  always @(negedge clk) begin
    cyc1  <= cyc1 + 1;
    prev1 <= link_clk1;
    if (link_clk1 && !prev1) begin
      rise1 <= rise1 + 1;
      cap1  <= {cap1[70:0], link_tx1};
      if (last_rise1 >= 0 && (cyc1 - last_rise1) != 2) gap_err1 <= gap_err1 + 1;
      last_rise1 <= cyc1;
    end else if (link_clk1 && prev1) begin
      gap_err1 <= gap_err1 + 1;
    end else if (!busy1) begin
      last_rise1 <= -1;
    end
  end

  function automatic logic [71:0] frame_of(input logic [7:0] a, input logic [63:0] d);
    return {a, d};
  endfunction

  task automatic wait_busy(input logic lvl, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy === lvl) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_tx(input logic [7:0] a, input logic [63:0] d, input logic [71:0] exp,
                       input string nm);
    bit ok;
    int r0, e0;
    exp_dir = 1'b1;
    r0 = rise_cnt;
    e0 = dir_err;
    @(negedge clk);
    tx_addr = a; tx_data = d; tx_valid = 1'b1;
    wait_busy(1'b1, 50, ok);
    tx_valid = 1'b0; tx_addr = ~a; tx_data = ~d;
    check({nm, " start"}, 72'(ok), 72'd1);
    wait_busy(1'b0, 1000, ok);
    check({nm, " done"}, 72'(ok), 72'd1);
    check({nm, " bits"}, cap, exp);
    check({nm, " rises"}, 72'(rise_cnt - r0), 72'd72);
    check({nm, " dir"}, 72'(dir_err - e0), 72'd0);
    check({nm, " ready/dir after"}, {70'd0, tx_ready, link_dir}, 72'b10);
  endtask

  task automatic do_rx(input logic [7:0] a, input logic [63:0] d, input logic [71:0] exp,
                       input string nm);
    bit ok;
    int r0, e0, pulses;
    logic [71:0] got;
    exp_dir = 1'b0;
    dev_frame = {a, d};
    dev_base = fall_cnt;
    r0 = rise_cnt;
    e0 = dir_err;
    pulses = 0;
    got = 72'd0;
    @(negedge clk);
    link_rts = 1'b1;
    wait_busy(1'b1, 20, ok);
    link_rts = 1'b0;
    check({nm, " start"}, 72'(ok), 72'd1);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (rx_valid) begin pulses++; got = {rx_addr, rx_data}; end
      if (!busy) break;
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rx_valid) pulses++;
    end
    check({nm, " pulses"}, 72'(pulses), 72'd1);
    check({nm, " data"}, got, exp);
    check({nm, " held"}, {rx_addr, rx_data}, exp);
    check({nm, " rises"}, 72'(rise_cnt - r0), 72'd72);
    check({nm, " dir"}, 72'(dir_err - e0), 72'd0);
  endtask

  typedef struct {
    bit          is_rx;
    logic [7:0]  addr;
    logic [63:0] data;
    logic [71:0] exp;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int r0, e0, n, highs, pulses;
    logic [7:0] a, ta;
    logic [63:0] d, td;
    logic [71:0] got;

    tbl[0] = '{1'b0, 8'h12, 64'hDEADBEEF_01234567, 72'h12_DEADBEEF_01234567};
    tbl[1] = '{1'b1, 8'hA5, 64'h0011223344556677, 72'hA5_0011223344556677};
    tbl[2] = '{1'b0, 8'h00, 64'h0000000000000000, 72'h00_0000000000000000};
    tbl[3] = '{1'b0, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 72'hFF_FFFFFFFFFFFFFFFF};
    tbl[4] = '{1'b1, 8'hFF, 64'h8000000000000001, 72'hFF_8000000000000001};
    tbl[5] = '{1'b1, 8'h01, 64'h5555AAAA5555AAAA, 72'h01_5555AAAA5555AAAA};

    tx_addr = 8'd0; tx_data = 64'd0; tx_valid = 1'b0;
    link_cts = 1'b1; link_rts = 1'b0;
    tx_addr1 = 8'd0; tx_data1 = 64'd0; tx_valid1 = 1'b0;
    link_cts1 = 1'b1; link_rts1 = 1'b0; link_rx1 = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset ctrl", {66'd0, tx_ready, busy, link_clk, link_dir, link_tx, rx_valid}, 72'd0);
    check("reset rx", {rx_addr, rx_data}, 72'd0);
    rst = 1'b1;
    #1 check("ready before first clk", 72'(tx_ready), 72'd0);
    @(negedge clk);
    check("ready after release", 72'(tx_ready), 72'd1);

    // Table-driven frames
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].is_rx) do_rx(tbl[i].addr, tbl[i].data, tbl[i].exp, $sformatf("vec%0d rx", i));
      else              do_tx(tbl[i].addr, tbl[i].data, tbl[i].exp, $sformatf("vec%0d tx", i));
    end

    // Random frames against the model
    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom);
      d = {32'($urandom), 32'($urandom)};
      if ($urandom_range(1, 0) == 1) do_rx(a, d, frame_of(a, d), $sformatf("rnd%0d rx", i));
      else                            do_tx(a, d, frame_of(a, d), $sformatf("rnd%0d tx", i));
    end

    // CTS stall, then cts drop mid-frame
    a = 8'hC3; d = 64'h0F1E2D3C4B5A6978;
    exp_dir = 1'b1; r0 = rise_cnt; e0 = dir_err;
    link_cts = 1'b0;
    repeat (3) @(negedge clk);
    tx_addr = a; tx_data = d; tx_valid = 1'b1;
    wait_busy(1'b1, 20, ok);
    tx_valid = 1'b0; tx_data = 64'd0;
    check("stall start", 72'(ok), 72'd1);
    highs = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (link_clk) highs++;
    end
    check("stall clk low", 72'(highs), 72'd0);
    check("stall dir/tx", {70'd0, link_dir, link_tx}, {70'd0, 1'b1, a[7]});
    link_cts = 1'b1;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (link_clk) break;
    end
    check("cts to first rise", 72'(n <= 5), 72'd1);
    repeat (40) @(negedge clk);
    link_cts = 1'b0;
    wait_busy(1'b0, 1000, ok);
    check("stall done", 72'(ok), 72'd1);
    check("stall bits", cap, frame_of(a, d));
    check("stall rises", 72'(rise_cnt - r0), 72'd72);
    link_cts = 1'b1;
    repeat (3) @(negedge clk);

    // Priority: rts and tx_valid both pending -> RX frame first, then TX
    a = 8'h3C; d = 64'h1234_5678_9ABC_DEF0;
    ta = 8'h5A; td = 64'hCAFEF00D_BAADC0DE;
    dev_frame = {a, d}; dev_base = fall_cnt;
    r0 = rise_cnt; e0 = dir_err; exp_dir = 1'b0;
    @(negedge clk);
    link_rts = 1'b1;
    repeat (2) @(negedge clk);
    check("prio ready low", 72'(tx_ready), 72'd0);
    tx_addr = ta; tx_data = td; tx_valid = 1'b1;
    wait_busy(1'b1, 20, ok);
    link_rts = 1'b0;
    check("prio rx start", 72'(ok), 72'd1);
    pulses = 0; got = 72'd0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (rx_valid) begin pulses++; got = {rx_addr, rx_data}; exp_dir = 1'b1; break; end
    end
    check("prio rx pulse", 72'(pulses), 72'd1);
    check("prio rx data", got, frame_of(a, d));
    check("prio rx rises", 72'(rise_cnt - r0), 72'd72);
    wait_busy(1'b1, 20, ok);
    tx_valid = 1'b0;
    check("prio tx start", 72'(ok), 72'd1);
    wait_busy(1'b0, 1000, ok);
    check("prio tx bits", cap, frame_of(ta, td));
    check("prio total rises", 72'(rise_cnt - r0), 72'd144);
    check("prio dir", 72'(dir_err - e0), 72'd0);

    // Reset at bit 40 of an RX frame
    dev_frame = {8'h77, 64'hFEDCBA9876543210}; dev_base = fall_cnt; exp_dir = 1'b0;
    @(negedge clk);
    link_rts = 1'b1;
    wait_busy(1'b1, 20, ok);
    link_rts = 1'b0;
    n = 0;
    while (n < 1000 && (fall_cnt - dev_base) < 40) begin
      @(negedge clk);
      n++;
    end
    check("reach bit 40", 72'(fall_cnt - dev_base), 72'd40);
    rst = 1'b0;
    #1;
    check("midreset ctrl", {66'd0, tx_ready, busy, link_clk, link_dir, link_tx, rx_valid}, 72'd0);
    check("midreset rx", {rx_addr, rx_data}, 72'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    pulses = 0; highs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rx_valid) pulses++;
      if (busy) highs++;
    end
    check("midreset no pulse/busy", 72'(pulses + highs), 72'd0);
    do_rx(8'h9B, 64'h0102030405060708, frame_of(8'h9B, 64'h0102030405060708), "post-reset rx");

    // HALF=1 back-to-back TX frames
    for (int k = 0; k < 4; k++) begin
      a = 8'($urandom);
      d = {32'($urandom), 32'($urandom)};
      r0 = rise1;
      tx_addr1 = a; tx_data1 = d; tx_valid1 = 1'b1;
      n = 0;
      while (n < 20 && !busy1) begin @(negedge clk); n++; end
      tx_valid1 = 1'b0; tx_data1 = ~d;
      n = 0;
      while (n < 400 && busy1) begin @(negedge clk); n++; end
      check($sformatf("h1 f%0d done", k), 72'(busy1), 72'd0);
      check($sformatf("h1 f%0d bits", k), cap1, frame_of(a, d));
      check($sformatf("h1 f%0d rises", k), 72'(rise1 - r0), 72'd72);
    end
    check("h1 half-period", 72'(gap_err1), 72'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/w6host.md
W6HOST -- requirements
Module: w6host

Interface
REQ-001 Parameter HALF, default 2, clk cycles per link_clk half-period (legal range 1..255).
REQ-002 Parameter FRAME_BITS, default 72, bits per frame (8 addr + 64 data).
REQ-003 clk  input  1  system clock; all logic on posedge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 tx_addr  input  8  address of the frame to send.
REQ-006 tx_data  input  64  payload of the frame to send.
REQ-007 tx_valid  input  1  send request; transfer occurs when tx_valid&tx_ready is high on a clk edge.
REQ-008 tx_ready  output  1  high only in IDLE with synced rts low.
REQ-009 rx_addr  output  8  address of the last received frame; held until the next frame completes.
REQ-010 rx_data  output  64  payload of the last received frame; held until the next frame completes.
REQ-011 rx_valid  output  1  one-cycle pulse when a received frame completes.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 link_clk  output  1  link clock; idles low.
REQ-014 link_dir  output  1  1 = host to device, 0 = device to host; idles 0.
REQ-015 link_cts  input  1  device ready to accept a frame; asynchronous.
REQ-016 link_rts  input  1  device has a frame to send; asynchronous.
REQ-017 link_tx  output  1  serial data to the device.
REQ-018 link_rx  input  1  serial data from the device.

Function
REQ-019 link_cts and link_rts shall pass through two-flop synchronizers; FSM uses only the synced copies.
REQ-020 States: IDLE, TX_WAIT, TX_SHIFT, TX_END, RX_SHIFT, RX_END.
REQ-021 IDLE: synced rts=1 -> RX_SHIFT (rx has priority over tx); else tx_valid&tx_ready -> capture {tx_addr,tx_data} into a 72-bit shifter -> TX_WAIT.
REQ-022 TX_WAIT: link_dir=1, link_tx=shifter[71]; synced cts=1 -> TX_SHIFT; waits indefinitely otherwise.
REQ-023 Each bit slot is HALF cycles link_clk low followed by HALF cycles link_clk high; frame = FRAME_BITS slots, MSB first.
REQ-024 TX_SHIFT: link_tx stable for the full slot; shifter shifts left and link_tx updates on the cycle link_clk falls; device samples on the rising edge.
REQ-025 A 7-bit bit counter counts completed slots; after slot 71 ends (link_clk falls), TX -> TX_END and RX -> RX_END.
REQ-026 TX_END: link_clk low, link_dir held 1 for HALF cycles, then link_dir=0 -> IDLE.
REQ-027 RX_SHIFT: link_dir=0; host samples link_rx into the LSB of the shifter (shift left) on the clk edge where link_clk rises.
REQ-028 RX_END: load rx_addr=shifter[71:64], rx_data=shifter[63:0], pulse rx_valid for exactly 1 cycle -> IDLE.
REQ-029 Frame duration: 2*HALF*72 cycles of link_clk activity (288 at HALF=2).
REQ-030 link_clk shall toggle only in TX_SHIFT and RX_SHIFT.
REQ-031 tx_valid deasserted or changed while not ready shall have no effect; captured data shall be unaffected by later input changes.
REQ-032 Synced rts falling mid-RX shall not abort; the frame completes.
REQ-033 Synced cts falling mid-TX shall not abort; the frame completes.
REQ-034 tx_valid high in RX_SHIFT or RX_END shall be accepted only after return to IDLE with rts low.

Reset
REQ-035 On rst low, asynchronously: state=IDLE, link_clk=0, link_dir=0, link_tx=0, tx_ready=0 until the first clk after release, rx_valid=0, rx_addr=0, rx_data=0, busy=0, counters=0, synchronizers=0.
REQ-036 Reset mid-frame shall abandon the frame with no rx_valid; the first request after release starts a fresh frame.

Verification
REQ-037 TX: HALF=2, cts=1, send addr 0x12, data 0xDEADBEEF_01234567 -> device model captures identical 72 bits; link_dir=1 throughout; tx_ready returns 1 after TX_END.
REQ-038 RX: rts=1, device shifts addr 0xA5, data 0x0011223344556677 -> single rx_valid pulse with matching values; link_dir=0 throughout; 72 link_clk rising edges.
REQ-039 Priority: tx_valid and rts rise together -> RX frame first, then TX frame, with no link_clk glitch between.
REQ-040 CTS stall: cts=0 for 500 cycles -> link_clk stays low in TX_WAIT; cts=1 -> frame starts within 3 cycles (sync + 1).
REQ-041 Reset at bit 40 of an RX frame -> all outputs at reset values immediately; no rx_valid; next RX frame received correctly.
REQ-042 HALF=1 back-to-back TX frames -> each link_clk half-period is exactly 1 clk; all bits correct.
